// File: rtl/kernel_feeder.sv
// kernel_feeder: upstream sequencer for the systolic kernel.
// Loads HEIGHT weight beats (plus bias), then streams i_num_cols input vectors
// through a diagonal skew (row r delayed r cycles), then drains zeros and pulses o_done.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_num_cols   job start pulse (honoured in IDLE) and vector count
//   i_w_valid/o_w_ready   weight beat handshake; i_w_row, i_w_bias beat payload
//   i_d_valid/o_d_ready   data vector handshake; i_d_col vector payload
//   o_loading_weight      weight shift enable to the kernel; o_weight, o_bias
//   o_data, o_data_vld    skewed data and per-row valid to the kernel
//   o_busy, o_done        activity flag and end-of-job pulse
//   o_stall_cnt           only with FEEDER_STALL_CNT_EN: STREAM cycles without i_d_valid
//
// Optional feature macro: FEEDER_STALL_CNT_EN
module kernel_feeder #(
    parameter int unsigned WIDTH        = 5,
    parameter int unsigned HEIGHT       = 5,
    parameter int unsigned BITWIDTH     = 16,
    parameter int unsigned DRAIN_CYCLES = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [15:0]                  i_num_cols,
    input  logic                         i_w_valid,
    output logic                         o_w_ready,
    input  logic [WIDTH*BITWIDTH-1:0]    i_w_row,
    input  logic [BITWIDTH-1:0]          i_w_bias,
    input  logic                         i_d_valid,
    output logic                         o_d_ready,
    input  logic [HEIGHT*BITWIDTH-1:0]   i_d_col,
    output logic                         o_loading_weight,
    output logic [WIDTH*BITWIDTH-1:0]    o_weight,
    output logic [BITWIDTH-1:0]          o_bias,
    output logic [HEIGHT*BITWIDTH-1:0]   o_data,
    output logic [HEIGHT-1:0]            o_data_vld,
    output logic                         o_busy,
    output logic                         o_done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                  o_stall_cnt
`endif
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned DRAIN_LEN = HEIGHT - 1 + DRAIN_CYCLES;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      num_cols_q, num_cols_d;

    logic start_acc;
    logic w_acc;
    logic d_acc;

    assign start_acc = i_start & (state_q == ST_IDLE);
    assign w_acc     = i_w_valid & o_w_ready;
    assign d_acc     = i_d_valid & o_d_ready;

    // Next state; one shared counter tracks beats, vectors or drain cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_cols_d = num_cols_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d    = ST_LOAD_W;
                    cnt_d      = '0;
                    num_cols_d = i_num_cols;
                end
            end
            ST_LOAD_W: begin
                if (w_acc) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = (num_cols_q == 16'd0) ? ST_DRAIN : ST_STREAM;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_STREAM: begin
                if (d_acc) begin
                    if (cnt_q + 16'd1 == num_cols_q) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered control/weight outputs (derived from next state).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            num_cols_q       <= '0;
            o_w_ready        <= 1'b0;
            o_d_ready        <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_loading_weight <= 1'b0;
            o_weight         <= '0;
            o_bias           <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            num_cols_q       <= num_cols_d;
            o_w_ready        <= (state_d == ST_LOAD_W);
            o_d_ready        <= (state_d == ST_STREAM);
            o_busy           <= (state_d != ST_IDLE);
            o_done           <= (state_d == ST_DRAIN) && (cnt_d == LAST_DRAIN);
            o_loading_weight <= w_acc;
            if (w_acc) begin
                o_weight <= i_w_row;
                o_bias   <= i_w_bias;
            end
        end
    end

    // Diagonal skew: row r = r delay stages + one output register; zeros enter on bubbles.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        logic [BITWIDTH-1:0] in_data;
        logic [BITWIDTH-1:0] out_q;
        logic                out_vld_q;

        assign in_data = d_acc ? i_d_col[r*BITWIDTH +: BITWIDTH] : '0;

        if (r == 0) begin : g_direct
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    out_q     <= '0;
                    out_vld_q <= 1'b0;
                end else begin
                    out_q     <= in_data;
                    out_vld_q <= d_acc;
                end
            end
        end else begin : g_chain
            logic [BITWIDTH-1:0] dly_q     [r];
            logic                dly_vld_q [r];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < r; k++) begin
                        dly_q[k]     <= '0;
                        dly_vld_q[k] <= 1'b0;
                    end
                    out_q     <= '0;
                    out_vld_q <= 1'b0;
                end else begin
                    dly_q[0]     <= in_data;
                    dly_vld_q[0] <= d_acc;
                    for (int k = 1; k < r; k++) begin
                        dly_q[k]     <= dly_q[k-1];
                        dly_vld_q[k] <= dly_vld_q[k-1];
                    end
                    out_q     <= dly_q[r-1];
                    out_vld_q <= dly_vld_q[r-1];
                end
            end
        end

        assign o_data[r*BITWIDTH +: BITWIDTH] = out_q;
        assign o_data_vld[r]                  = out_vld_q;
    end

`ifdef FEEDER_STALL_CNT_EN
    // Saturating count of STREAM cycles with no offered vector.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (start_acc) begin
            o_stall_cnt <= '0;
        end else if ((state_q == ST_STREAM) && !i_d_valid && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_feeder.sv
// Self-checking bench for kernel_feeder (WIDTH=HEIGHT=3, BITWIDTH=16, DRAIN_CYCLES=4).
// A job-level reference model predicts ready/busy/done from phase counters and the
// skewed outputs from a per-cycle log of accepted vectors (row r = vector from cycle n-1-r).
module tb_kernel_feeder;

    localparam int unsigned W  = 3;
    localparam int unsigned H  = 3;
    localparam int unsigned BW = 16;
    localparam int unsigned DC = 4;
    localparam int DRAIN_TOTAL = H - 1 + DC;
    localparam int MAXC        = 8192;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_STREAM = 2;
    localparam int P_DRAIN  = 3;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic [15:0]       i_num_cols = '0;
    logic              i_w_valid = 1'b0;
    logic              o_w_ready;
    logic [W*BW-1:0]   i_w_row = '0;
    logic [BW-1:0]     i_w_bias = '0;
    logic              i_d_valid = 1'b0;
    logic              o_d_ready;
    logic [H*BW-1:0]   i_d_col = '0;
    logic              o_loading_weight;
    logic [W*BW-1:0]   o_weight;
    logic [BW-1:0]     o_bias;
    logic [H*BW-1:0]   o_data;
    logic [H-1:0]      o_data_vld;
    logic              o_busy;
    logic              o_done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]       o_stall_cnt;
`endif

    kernel_feeder #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .BITWIDTH     (BW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_num_cols       (i_num_cols),
        .i_w_valid        (i_w_valid),
        .o_w_ready        (o_w_ready),
        .i_w_row          (i_w_row),
        .i_w_bias         (i_w_bias),
        .i_d_valid        (i_d_valid),
        .o_d_ready        (o_d_ready),
        .i_d_col          (i_d_col),
        .o_loading_weight (o_loading_weight),
        .o_weight         (o_weight),
        .o_bias           (o_bias),
        .o_data           (o_data),
        .o_data_vld       (o_data_vld),
        .o_busy           (o_busy),
        .o_done           (o_done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .o_stall_cnt      (o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int              n = 0;
    int              rst_mark = 0;
    int              m_phase = P_IDLE;
    int              m_cnt = 0;
    int              m_ncols = 0;
    logic [W*BW-1:0] m_wt = '0;
    logic [BW-1:0]   m_bias = '0;
    logic            m_load = 1'b0;
    logic [15:0]     m_stall = '0;
    logic [H*BW-1:0] hd [MAXC];
    bit              hv [MAXC];
    int              load_cycles;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    function automatic logic [47:0] pk3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return {c, b, a};
    endfunction

    task automatic check_outputs();
        logic [H*BW-1:0] ed;
        logic [H-1:0]    ev;
        ed = '0;
        ev = '0;
        for (int r = 0; r < H; r++) begin
            int idx;
            idx = n - 1 - r;
            if (idx >= rst_mark && idx >= 0) begin
                ev[r]           = hv[idx % MAXC];
                ed[r*BW +: BW]  = hd[idx % MAXC][r*BW +: BW];
            end
        end
        check_eq("w_ready", 64'(o_w_ready), 64'(m_phase == P_LOAD));
        check_eq("d_ready", 64'(o_d_ready), 64'(m_phase == P_STREAM));
        check_eq("busy",    64'(o_busy),    64'(m_phase != P_IDLE));
        check_eq("done",    64'(o_done),    64'(m_phase == P_DRAIN && m_cnt == DRAIN_TOTAL - 1));
        check_eq("loading", 64'(o_loading_weight), 64'(m_load));
        check_eq("weight",  64'(o_weight),  64'(m_wt));
        check_eq("bias",    64'(o_bias),    64'(m_bias));
        check_eq("data",    64'(o_data),    64'(ed));
        check_eq("vld",     64'(o_data_vld), 64'(ev));
`ifdef FEEDER_STALL_CNT_EN
        check_eq("stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check the following cycle.
    task automatic step(input logic start, input logic [15:0] ncols, input logic wv,
                        input logic [W*BW-1:0] wrow, input logic [BW-1:0] wb,
                        input logic dv, input logic [H*BW-1:0] dcol);
        bit w_acc;
        bit d_acc;
        i_start    = start;
        i_num_cols = ncols;
        i_w_valid  = wv;
        i_w_row    = wrow;
        i_w_bias   = wb;
        i_d_valid  = dv;
        i_d_col    = dcol;
        w_acc = (m_phase == P_LOAD) && wv;
        d_acc = (m_phase == P_STREAM) && dv;
        hd[n % MAXC] = d_acc ? dcol : '0;
        hv[n % MAXC] = d_acc;
        m_load = w_acc;
        if (w_acc) begin
            m_wt   = wrow;
            m_bias = wb;
        end
        if (m_phase == P_IDLE && start)
            m_stall = '0;
        else if (m_phase == P_STREAM && !dv && m_stall != 16'hFFFF)
            m_stall = m_stall + 16'd1;
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_LOAD;
                m_cnt   = 0;
                m_ncols = int'(ncols);
            end
            P_LOAD: if (w_acc) begin
                m_cnt++;
                if (m_cnt == H) begin
                    m_cnt   = 0;
                    m_phase = (m_ncols == 0) ? P_DRAIN : P_STREAM;
                end
            end
            P_STREAM: if (d_acc) begin
                m_cnt++;
                if (m_cnt == m_ncols) begin
                    m_cnt   = 0;
                    m_phase = P_DRAIN;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == DRAIN_TOTAL) begin
                    m_cnt   = 0;
                    m_phase = P_IDLE;
                end
            end
        endcase
        @(posedge i_clk);
        #1;
        n++;
        if (o_loading_weight) load_cycles++;
        check_outputs();
    endtask

    task automatic idle_step();
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_w_valid = 1'b0;
        i_d_valid = 1'b0;
        #2;
        check_eq("rst_busy", 64'(o_busy), 64'(0));
        check_eq("rst_vld",  64'(o_data_vld), 64'(0));
        check_eq("rst_data", 64'(o_data), 64'(0));
        check_eq("rst_done", 64'(o_done), 64'(0));
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        n++;
        m_phase  = P_IDLE;
        m_cnt    = 0;
        m_wt     = '0;
        m_bias   = '0;
        m_load   = 1'b0;
        m_stall  = '0;
        rst_mark = n;
        check_outputs();
    endtask

    task automatic finish_job();
        int g;
        g = 0;
        while (m_phase != P_IDLE && g < 300) begin
            idle_step();
            g++;
        end
        check_eq("job_end_busy", 64'(o_busy), 64'(0));
        check_eq("job_end_in_budget", 64'(g < 300), 64'(1));
    endtask

    task automatic rand_job(input int ncols, input int pw, input int pd);
        int g;
        g = 0;
        step(1'b1, 16'(ncols), 1'b0, '0, '0, 1'b1, 48'({$urandom(), $urandom()}));
        while (m_phase != P_IDLE && g < 400) begin
            step($urandom_range(0, 7) == 0, 16'($urandom()), $urandom_range(0, 99) < pw,
                 48'({$urandom(), $urandom()}), 16'($urandom()),
                 $urandom_range(0, 99) < pd, 48'({$urandom(), $urandom()}));
            g++;
        end
        check_eq("rand_job_end_busy", 64'(o_busy), 64'(0));
        check_eq("rand_job_in_budget", 64'(g < 400), 64'(1));
    endtask

    initial begin
        #1;
        do_reset();

        // Back-to-back weights and vectors.
        idle_step();
        step(1'b1, 16'd2, 1'b0, '0, '0, 1'b0, '0);
        load_cycles = 0;
        step(1'b0, 16'd0, 1'b1, pk3(1, 2, 3), 16'd5, 1'b0, '0);
        step(1'b0, 16'd0, 1'b1, pk3(4, 5, 6), 16'd6, 1'b0, '0);
        step(1'b0, 16'd0, 1'b1, pk3(7, 8, 9), 16'd7, 1'b0, '0);
        check_eq("bias_after_load", 64'(o_bias), 64'(7));
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b1, pk3(1, 2, 3));
        check_eq("row0_first", 64'(o_data[15:0]), 64'(1));
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b1, pk3(4, 5, 6));
        check_eq("row0_second", 64'(o_data[15:0]), 64'(4));
        check_eq("row1_first", 64'(o_data[31:16]), 64'(2));
        finish_job();
        check_eq("load_cycle_count", 64'(load_cycles), 64'(3));

        // Gapped weight valid and a data bubble; spurious start while busy.
        step(1'b1, 16'd2, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, 16'd0, 1'b1, pk3(11, 12, 13), 16'd21, 1'b0, '0);
        step(1'b1, 16'd9, 1'b0, pk3(99, 99, 99), 16'd99, 1'b0, '0);
        step(1'b0, 16'd0, 1'b1, pk3(14, 15, 16), 16'd22, 1'b0, '0);
        step(1'b0, 16'd0, 1'b1, pk3(17, 18, 19), 16'd23, 1'b0, '0);
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b1, pk3(1, 2, 3));
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b0, pk3(7, 7, 7));
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b1, pk3(4, 5, 6));
        finish_job();

        // Zero-length job: LOAD_W then straight to DRAIN.
        step(1'b1, 16'd0, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < H; i++)
            step(1'b0, 16'd0, 1'b1, pk3(16'(i), 16'(i + 1), 16'(i + 2)), 16'(30 + i), 1'b1, pk3(5, 5, 5));
        finish_job();

        // Reset in the middle of STREAM, then a fresh job.
        step(1'b1, 16'd5, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < H; i++)
            step(1'b0, 16'd0, 1'b1, pk3(16'(40 + i), 16'd1, 16'd2), 16'(50 + i), 1'b0, '0);
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b1, pk3(8, 9, 10));
        step(1'b0, 16'd0, 1'b0, '0, '0, 1'b1, pk3(11, 12, 13));
        do_reset();
        rand_job(3, 100, 100);

        // Randomised jobs.
        for (int j = 0; j < 8; j++)
            rand_job($urandom_range(0, 6), $urandom_range(30, 100), $urandom_range(30, 100));
        for (int i = 0; i < 5; i++)
            idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", n);
        $fatal(1);
    end

endmodule
